// File: rtl/xbus_pkg.sv
// Shared types and default widths for the xbus arbiter family.
package xbus_pkg;

   typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWNED = 2'd1,
      ERR   = 2'd2
   } xbus_state_e;

   localparam int XBUS_NUM_MASTERS = 4;
   localparam int XBUS_ADDR_W      = 32;
   localparam int XBUS_DATA_W      = 32;
   localparam int XBUS_MAX_DATA_W  = 1024;

   // Read data returned with an error acknowledge; sliced to DATA_W by users.
   localparam logic [XBUS_MAX_DATA_W-1:0] XBUS_ERR_DATA = '0;

endpackage

// File: rtl/xbus_arb_pick.sv
// Rotating priority picker: first candidate at or above 'start', wrapping,
// with masters in 'excl' removed from contention.
module xbus_arb_pick
   import xbus_pkg::*;
#(
   parameter  int N  = XBUS_NUM_MASTERS,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   input  logic [N-1:0]  excl,
   output logic [N-1:0]  win,
   output logic          valid
);

   logic [N-1:0]   cand;
   logic [N-1:0]   rot;
   logic [N-1:0]   rot_hot;
   logic [2*N-1:0] dbl_rot;
   logic [2*N-1:0] dbl_back;

   // Rotate so 'start' sits at bit 0, keep the lowest set bit, rotate back.
   always_comb begin
      cand     = req & ~excl;
      dbl_rot  = {cand, cand} >> start;
      rot      = dbl_rot[N-1:0];
      rot_hot  = rot & (-rot);
      dbl_back = {rot_hot, rot_hot} << start;
      win      = dbl_back[2*N-1:N];
      valid    = |cand;
   end

endmodule

// File: rtl/xbus_arbiter_n.sv
// N-master xbus arbiter and datapath mux in front of the single xbus slave,
// with fixed/round-robin arbitration, a burst cap and a slave-timeout watchdog.
module xbus_arbiter_n
   import xbus_pkg::*;
#(
   parameter int NUM_MASTERS    = XBUS_NUM_MASTERS,
   parameter int ADDR_W         = XBUS_ADDR_W,
   parameter int DATA_W         = XBUS_DATA_W,
   parameter int ARB_MODE       = 1,
   parameter int MAX_BEATS      = 0,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic [NUM_MASTERS-1:0]          ma_req,
   output logic [NUM_MASTERS-1:0]          xbm_gnt,
   input  logic [NUM_MASTERS-1:0]          ma_select,
   input  logic [NUM_MASTERS*ADDR_W-1:0]   ma_addr,
   input  logic [NUM_MASTERS*DATA_W-1:0]   ma_data,
   input  logic [NUM_MASTERS-1:0]          ma_rnw,
   input  logic [NUM_MASTERS*DATA_W/8-1:0] ma_be,
   output logic [NUM_MASTERS-1:0]          xbm_ack,
   output logic [NUM_MASTERS-1:0]          xbm_err,
   output logic [DATA_W-1:0]               xbm_data,
   output logic                            xbs_select,
   output logic [ADDR_W-1:0]               xbs_addr,
   output logic [DATA_W-1:0]               xbs_data,
   output logic                            xbs_rnw,
   output logic [DATA_W/8-1:0]             xbs_be,
   input  logic                            sl_ack,
   input  logic [DATA_W-1:0]               sl_data,
   output logic [1:0]                      dbg_state
);

   // Handshake: a master raises ma_req and waits for xbm_gnt. While granted,
   // every cycle with ma_select high is a transfer that completes in the cycle
   // xbm_ack is high (xbm_err marks a watchdog abort). The master releases the
   // bus by sampling ma_req low together with ma_select low.

   localparam int N      = NUM_MASTERS;
   localparam int IW     = $clog2(N);
   localparam int BE_W   = DATA_W / 8;
   localparam int BW     = $clog2(MAX_BEATS + 2);
   localparam int WD_LIM = (TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 1 : 1;
   localparam int WW     = $clog2(WD_LIM + 1);

   localparam logic [BW-1:0] BEAT_CAP = BW'(MAX_BEATS);
   localparam logic [WW-1:0] WD_LAST  = WW'(WD_LIM - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   xbus_state_e   state_q;
   logic [N-1:0]  gnt_q;
   logic [IW-1:0] owner_q;
   logic [IW-1:0] last_q;
   logic [BW-1:0] beat_q;
   logic [WW-1:0] wd_q;

   logic          owner_req;
   logic          owner_sel;
   logic          ack_now;
   logic          release_ev;
   logic          cap_move;
   logic          wd_fire;
   logic [BW-1:0] beat_sum;
   logic [IW-1:0] pick_start;
   logic [IW-1:0] pick_idx;
   logic [N-1:0]  pick_win;
   logic          pick_valid;

   // The owner is excluded while it holds the bus; in IDLE gnt_q is all zero.
   xbus_arb_pick #(.N(N)) u_pick (
      .req   (ma_req),
      .start (pick_start),
      .excl  (gnt_q),
      .win   (pick_win),
      .valid (pick_valid)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < N; i++)
         if (pick_win[i]) pick_idx = IW'(i);
   end

   assign pick_start = (ARB_MODE == int'(ARB_FIXED)) ? '0 :
                       ((last_q == LAST_IDX) ? '0 : last_q + IW'(1));

   assign owner_req  = ma_req[owner_q];
   assign owner_sel  = ma_select[owner_q];
   assign ack_now    = ((state_q == OWNED) && sl_ack) || (state_q == ERR);
   assign release_ev = !owner_req && !owner_sel;
   assign beat_sum   = beat_q + BW'(ack_now);
   // Never pull the grant from under a transfer that is still waiting.
   assign cap_move   = (MAX_BEATS != 0) && (beat_sum >= BEAT_CAP) && pick_valid &&
                       (!owner_sel || ack_now);
   assign wd_fire    = (TIMEOUT_CYCLES != 0) && xbs_select && !sl_ack && (wd_q == WD_LAST);

   assign xbm_gnt    = gnt_q;
   assign xbm_ack    = gnt_q & {N{ack_now}};
   assign xbm_err    = gnt_q & {N{state_q == ERR}};
   assign xbm_data   = (state_q == ERR) ? XBUS_ERR_DATA[DATA_W-1:0] : sl_data;
   assign xbs_select = (state_q == OWNED) && owner_sel && gnt_q[owner_q];
   assign xbs_addr   = ma_addr[int'(owner_q)*ADDR_W +: ADDR_W];
   assign xbs_data   = ma_data[int'(owner_q)*DATA_W +: DATA_W];
   assign xbs_be     = ma_be[int'(owner_q)*BE_W +: BE_W];
   assign xbs_rnw    = ma_rnw[owner_q];
   assign dbg_state  = state_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         owner_q <= '0;
         last_q  <= LAST_IDX;
         beat_q  <= '0;
         wd_q    <= '0;
      end else begin
         wd_q <= ((TIMEOUT_CYCLES != 0) && xbs_select && !sl_ack && !wd_fire) ?
                 wd_q + WW'(1) : '0;
         case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  state_q <= OWNED;
                  gnt_q   <= pick_win;
                  owner_q <= pick_idx;
                  last_q  <= pick_idx;
                  beat_q  <= '0;
               end
            end
            OWNED, ERR: begin
               if (release_ev || cap_move) begin
                  beat_q <= '0;
                  if (pick_valid) begin
                     state_q <= OWNED;
                     gnt_q   <= pick_win;
                     owner_q <= pick_idx;
                     last_q  <= pick_idx;
                  end else begin
                     state_q <= IDLE;
                     gnt_q   <= '0;
                  end
               end else begin
                  state_q <= wd_fire ? ERR : OWNED;
                  if (ack_now && (beat_q != BEAT_CAP)) beat_q <= beat_q + BW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               gnt_q   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_xbus_arbiter_n.sv
// Directed bench: three arbiter configurations (fixed; round robin with a
// one-beat cap; round robin with a four-beat cap and a 16-cycle watchdog).
module tb_xbus_arbiter_n;

   logic        clk = 1'b0;
   logic        rstn;

   logic [3:0]  req   [3];
   logic [3:0]  sel   [3];
   logic [3:0]  rnw   [3];
   logic [63:0] addr  [3];
   logic [63:0] wdat  [3];
   logic [7:0]  be    [3];
   logic        sack  [3];
   logic [15:0] sdata [3];
   logic [3:0]  gnt   [3];
   logic [3:0]  ack   [3];
   logic [3:0]  err   [3];
   logic [15:0] mdata [3];
   logic        xsel  [3];
   logic [15:0] xaddr [3];
   logic [15:0] xdata [3];
   logic        xrnw  [3];
   logic [1:0]  xbe   [3];
   logic [1:0]  st    [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      xbus_arbiter_n #(
         .NUM_MASTERS    (4),
         .ADDR_W         (16),
         .DATA_W         (16),
         .ARB_MODE       ((k == 0) ? 0 : 1),
         .MAX_BEATS      ((k == 0) ? 0 : ((k == 1) ? 1 : 4)),
         .TIMEOUT_CYCLES ((k == 2) ? 16 : 0)
      ) u_dut (
         .clk        (clk),
         .rstn       (rstn),
         .ma_req     (req[k]),
         .xbm_gnt    (gnt[k]),
         .ma_select  (sel[k]),
         .ma_addr    (addr[k]),
         .ma_data    (wdat[k]),
         .ma_rnw     (rnw[k]),
         .ma_be      (be[k]),
         .xbm_ack    (ack[k]),
         .xbm_err    (err[k]),
         .xbm_data   (mdata[k]),
         .xbs_select (xsel[k]),
         .xbs_addr   (xaddr[k]),
         .xbs_data   (xdata[k]),
         .xbs_rnw    (xrnw[k]),
         .xbs_be     (xbe[k]),
         .sl_ack     (sack[k]),
         .sl_data    (sdata[k]),
         .dbg_state  (st[k])
      );
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rstn = 1'b0;
      for (int k = 0; k < 3; k++) begin
         req[k]   = 4'hF;
         sel[k]   = 4'hF;
         rnw[k]   = 4'h0;
         addr[k]  = 64'h4444_3333_2222_1111;
         wdat[k]  = 64'hD3D3_C2C2_B1B1_A0A0;
         be[k]    = 8'b11_10_01_00;
         sack[k]  = 1'b0;
         sdata[k] = 16'h0000;
      end

      // reset held while every master requests and selects
      for (int c = 0; c < 2; c++) begin
         cyc();
         for (int k = 0; k < 3; k++) begin
            check("rst_gnt", 32'(gnt[k]), 0);
            check("rst_sel", 32'(xsel[k]), 0);
            check("rst_state", 32'(st[k]), 0);
         end
      end
      rstn = 1'b1;
      cyc();
      for (int k = 0; k < 3; k++) check("first_gnt", 32'(gnt[k]), 1);
      for (int k = 0; k < 3; k++) begin
         req[k] = 4'h0;
         sel[k] = 4'h0;
      end
      cyc();
      for (int k = 0; k < 3; k++) check("idle_gnt", 32'(gnt[k]), 0);

      // fixed priority on instance 0
      req[0] = 4'b1010;
      cyc();
      check("fix_gnt_1", 32'(gnt[0]), 2);
      check("fix_addr_1", 32'(xaddr[0]), 'h2222);
      req[0] = 4'b1000;
      cyc();
      check("fix_gnt_3", 32'(gnt[0]), 8);
      check("fix_addr_3", 32'(xaddr[0]), 'h4444);
      check("fix_be_3", 32'(xbe[0]), 3);
      check("fix_data_3", 32'(xdata[0]), 'hD3D3);
      sel[0]   = 4'b1010;
      sack[0]  = 1'b1;
      sdata[0] = 16'hBEEF;
      #1;
      check("fix_xsel", 32'(xsel[0]), 1);
      check("fix_ack_owner_only", 32'(ack[0]), 8);
      check("fix_rdata", 32'(mdata[0]), 'hBEEF);
      check("fix_err", 32'(err[0]), 0);
      req[0]  = 4'b0000;
      sack[0] = 1'b0;
      cyc();
      check("fix_hold_on_select", 32'(gnt[0]), 8);
      sel[0] = 4'b0000;
      cyc();
      check("fix_release_idle", 32'(gnt[0]), 0);
      req[0] = 4'b0110;
      cyc();
      check("fix_gnt_low", 32'(gnt[0]), 2);
      req[0] = 4'b0101;
      cyc();
      check("fix_lowest_wins", 32'(gnt[0]), 1);
      req[0] = 4'b0000;
      cyc();
      check("fix_idle_again", 32'(gnt[0]), 0);

      // round robin, one beat per tenure, on instance 1 from a fresh reset
      req[1] = 4'hF;
      sel[1] = 4'hF;
      rstn = 1'b0;
      #1;
      rstn = 1'b1;
      cyc();
      for (int g = 0; g < 5; g++) begin
         check("rr_gnt", 32'(gnt[1]), 1 << (g % 4));
         check("rr_xsel", 32'(xsel[1]), 1);
         cyc();
         sack[1] = 1'b1;
         #1;
         check("rr_ack", 32'(ack[1]), 1 << (g % 4));
         cyc();
         sack[1] = 1'b0;
      end
      check("rr_after_wrap", 32'(gnt[1]), 2);
      req[1] = 4'h0;
      sel[1] = 4'h0;
      cyc();
      check("rr_idle", 32'(gnt[1]), 0);

      // burst cap of four beats on instance 2
      req[2] = 4'b0001;
      cyc();
      check("cap_gnt_0", 32'(gnt[2]), 1);
      sel[2]  = 4'b0001;
      rnw[2]  = 4'b0001;
      sack[2] = 1'b1;
      for (int b = 1; b <= 4; b++) begin
         sdata[2] = 16'h0A00 + 16'(b);
         #1;
         check("cap_ack", 32'(ack[2]), 1);
         check("cap_rdata", 32'(mdata[2]), 32'h0A00 + 32'(b));
         check("cap_rnw", 32'(xrnw[2]), 1);
         cyc();
         if (b == 1) req[2] = 4'b0101;
         check("cap_gnt", 32'(gnt[2]), (b < 4) ? 1 : 4);
      end

      // watchdog: master 2 selects and the slave never answers
      req[2]   = 4'b0100;
      sel[2]   = 4'b0100;
      rnw[2]   = 4'b0000;
      sack[2]  = 1'b0;
      sdata[2] = 16'h5A5A;
      for (int c = 1; c <= 15; c++) begin
         #1;
         check("wd_select", 32'(xsel[2]), 1);
         check("wd_no_ack", 32'(ack[2]), 0);
         cyc();
      end
      #1;
      check("wd_err_ack", 32'(ack[2]), 4);
      check("wd_err_flag", 32'(err[2]), 4);
      check("wd_err_data", 32'(mdata[2]), 0);
      check("wd_err_select", 32'(xsel[2]), 0);
      check("wd_err_state", 32'(st[2]), 2);
      sack[2] = 1'b1;
      #1;
      check("wd_err_ignores_slave", 32'(mdata[2]), 0);
      cyc();
      sack[2] = 1'b0;
      sel[2]  = 4'b0000;
      #1;
      check("wd_back_owned", 32'(st[2]), 1);
      check("wd_err_clear", 32'(err[2]), 0);
      check("wd_gnt_kept", 32'(gnt[2]), 4);

      // asynchronous reset in the middle of a transfer
      sel[2] = 4'b0100;
      #1;
      check("mid_select", 32'(xsel[2]), 1);
      rstn = 1'b0;
      #1;
      check("mid_rst_gnt", 32'(gnt[2]), 0);
      check("mid_rst_select", 32'(xsel[2]), 0);
      check("mid_rst_state", 32'(st[2]), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
